// File: rtl/mem_access_unit_if.sv
// Pipeline-side request/response bundle for mem_access_unit.
// The pipeline is the master; the access unit is the slave.
interface mem_access_unit_if;
  logic        Req_Valid;
  logic        Req_Ready;
  logic        Req_Write;
  logic [1:0]  Req_Size;
  logic        Req_Unsigned;
  logic [31:0] Req_Address;
  logic [31:0] Req_Wdata;
  logic        Resp_Valid;
  logic [31:0] Resp_Data;
  logic        Resp_Error;

  modport master (
    output Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address, Req_Wdata,
    input  Req_Ready, Resp_Valid, Resp_Data, Resp_Error
  );

  modport slave (
    input  Req_Valid, Req_Write, Req_Size, Req_Unsigned, Req_Address, Req_Wdata,
    output Req_Ready, Resp_Valid, Resp_Data, Resp_Error
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-addressed data memory with byte/halfword support.
// Sub-word stores are read-modify-write; sub-word loads are extracted and extended.
module mem_access_unit #(
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_access_unit_if.slave req_if,
  output logic [31:0]      Address,
  output logic [31:0]      Write_Data,
  output logic             MemWrite,
  output logic             MemRead,
  input  logic [31:0]      Read_Data
);
  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] address_q, address_d;
  logic [31:0] write_data_q, write_data_d;
  logic        mem_write_q, mem_write_d;
  logic        mem_read_q, mem_read_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_error_q, resp_error_d;

  logic [31:0] word_idx;
  logic        req_err;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size,
                                          input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Only the addressed lane is replaced; the rest of the word comes from memory.
  function automatic logic [31:0] merge(input logic [31:0] w, input logic [15:0] wd,
                                        input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = w;
    if (size == 2'b00) m[{lane, 3'b000} +: 8] = wd[7:0];
    else               m[{lane[1], 4'b0000} +: 16] = wd;
    return m;
  endfunction

  assign word_idx = {2'b00, req_if.Req_Address[31:2]};
  assign req_err  = (req_if.Req_Size == 2'b11) ||
                    (req_if.Req_Size == 2'b01 && req_if.Req_Address[0]) ||
                    (req_if.Req_Size == 2'b10 && req_if.Req_Address[1:0] != 2'b00) ||
                    (word_idx >= DEPTH);

  always_comb begin
    state_d      = state_q;
    write_d      = write_q;
    size_d       = size_q;
    uns_d        = uns_q;
    lane_d       = lane_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    write_data_d = write_data_q;
    mem_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_error_d = resp_error_q;
    unique case (state_q)
      StIdle: begin
        if (req_if.Req_Valid) begin
          write_d = req_if.Req_Write;
          size_d  = req_if.Req_Size;
          uns_d   = req_if.Req_Unsigned;
          lane_d  = req_if.Req_Address[1:0];
          wdata_d = req_if.Req_Wdata[15:0];
          if (req_err) begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
            resp_data_d  = 32'h0;
          end else begin
            address_d = word_idx;
            if (req_if.Req_Write && req_if.Req_Size == 2'b10) begin
              state_d      = StWrite;
              mem_write_d  = 1'b1;
              write_data_d = req_if.Req_Wdata;
            end else begin
              state_d    = StRead;
              mem_read_d = 1'b1;
              cnt_d      = 4'(READ_LATENCY - 1);
            end
          end
        end
      end
      StRead: begin
        if (cnt_q == 4'd0) begin
          if (write_q) begin
            state_d      = StWrite;
            mem_write_d  = 1'b1;
            write_data_d = merge(Read_Data, wdata_q, size_q, lane_q);
          end else begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            resp_data_d  = extract(Read_Data, size_q, lane_q, uns_q);
          end
        end else begin
          cnt_d      = cnt_q - 4'd1;
          mem_read_d = 1'b1;
        end
      end
      StWrite: begin
        state_d      = StResp;
        resp_valid_d = 1'b1;
        resp_error_d = 1'b0;
        resp_data_d  = 32'h0;
      end
      StResp: begin
        state_d      = StIdle;
        resp_data_d  = 32'h0;
        resp_error_d = 1'b0;
      end
    endcase
  end

  // Async reset clears the strobes immediately and drops any in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      lane_q       <= 2'b00;
      wdata_q      <= 16'h0;
      cnt_q        <= 4'd0;
      address_q    <= 32'h0;
      write_data_q <= 32'h0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      lane_q       <= lane_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      write_data_q <= write_data_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_if.Req_Ready  = (state_q == StIdle);
  assign req_if.Resp_Valid = resp_valid_q;
  assign req_if.Resp_Data  = resp_data_q;
  assign req_if.Resp_Error = resp_error_q;
  assign Address           = address_q;
  assign Write_Data        = write_data_q;
  assign MemWrite          = mem_write_q;
  assign MemRead           = mem_read_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (read latency 1 and 3) against a byte-level
// reference model of memory contents, load results, errors and completion timing.
module tb_mem_access_unit;
  localparam int unsigned Depth = 256;
  localparam int unsigned LatA  = 1;
  localparam int unsigned LatB  = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if bus_a ();
  mem_access_unit_if bus_b ();

  logic [31:0] addr_a, wd_a, rd_a, addr_b, wd_b, rd_b;
  logic        mw_a, mr_a, mw_b, mr_b;
  logic [31:0] mem_a [Depth];
  logic [31:0] mem_b [Depth];
  logic [31:0] ref_a [Depth];
  logic [31:0] ref_b [Depth];

  assign rd_a = mem_a[addr_a[7:0]];
  assign rd_b = mem_b[addr_b[7:0]];

  mem_access_unit #(.DEPTH(Depth), .READ_LATENCY(LatA)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_if(bus_a), .Address(addr_a), .Write_Data(wd_a),
    .MemWrite(mw_a), .MemRead(mr_a), .Read_Data(rd_a)
  );

  mem_access_unit #(.DEPTH(Depth), .READ_LATENCY(LatB)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_if(bus_b), .Address(addr_b), .Write_Data(wd_b),
    .MemWrite(mw_b), .MemRead(mr_b), .Read_Data(rd_b)
  );

  bit          sel = 1'b0;
  logic        v_ready, v_rv, v_rerr, v_mr, v_mw;
  logic [31:0] v_rdata, v_addr, v_wd;
  assign v_ready = sel ? bus_b.Req_Ready  : bus_a.Req_Ready;
  assign v_rv    = sel ? bus_b.Resp_Valid : bus_a.Resp_Valid;
  assign v_rerr  = sel ? bus_b.Resp_Error : bus_a.Resp_Error;
  assign v_rdata = sel ? bus_b.Resp_Data  : bus_a.Resp_Data;
  assign v_mr    = sel ? mr_b : mr_a;
  assign v_mw    = sel ? mw_b : mw_a;
  assign v_addr  = sel ? addr_b : addr_a;
  assign v_wd    = sel ? wd_b : wd_a;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory viewed as four bytes, lane 0 least significant.
  function automatic void model(input logic [31:0] word, input bit wr, input logic [1:0] size,
                                input bit uns, input logic [31:0] addr,
                                input logic [31:0] wdata, output bit err,
                                output logic [31:0] rdata, output logic [31:0] new_word);
    logic [7:0]  bytes [4];
    logic [31:0] tmp;
    int          lane, hl;
    lane = int'(addr % 4);
    hl   = (lane >= 2) ? 2 : 0;
    for (int i = 0; i < 4; i++) begin
      tmp      = word >> (8 * i);
      bytes[i] = tmp[7:0];
    end
    err = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) ||
          (size == 2'd2 && lane != 0) || ((addr / 4) >= Depth);
    rdata    = 32'h0;
    new_word = word;
    if (err) return;
    if (!wr) begin
      if (size == 2'd0) begin
        rdata = 32'(bytes[lane]);
        if (!uns && rdata >= 128) rdata = rdata + 32'hFFFF_FF00;
      end else if (size == 2'd1) begin
        rdata = 32'(bytes[hl]) + 256 * 32'(bytes[hl + 1]);
        if (!uns && rdata >= 32768) rdata = rdata + 32'hFFFF_0000;
      end else begin
        rdata = word;
      end
    end else begin
      if (size == 2'd0) begin
        bytes[lane] = wdata[7:0];
      end else if (size == 2'd1) begin
        bytes[hl]     = wdata[7:0];
        bytes[hl + 1] = wdata[15:8];
      end
      new_word = (size == 2'd2) ? wdata : {bytes[3], bytes[2], bytes[1], bytes[0]};
    end
  endfunction

  task automatic set_req(input bit s, input bit v, input bit wr, input logic [1:0] size,
                         input bit uns, input logic [31:0] addr, input logic [31:0] wdata);
    bus_a.Req_Write = wr;  bus_a.Req_Size = size; bus_a.Req_Unsigned = uns;
    bus_a.Req_Address = addr; bus_a.Req_Wdata = wdata;
    bus_b.Req_Write = wr;  bus_b.Req_Size = size; bus_b.Req_Unsigned = uns;
    bus_b.Req_Address = addr; bus_b.Req_Wdata = wdata;
    bus_a.Req_Valid = v && !s;
    bus_b.Req_Valid = v && s;
  endtask

  // Waits (bounded) for Req_Ready, then lets one edge accept; returns #1 after that edge.
  task automatic accept(output bit ok);
    int n;
    n = 0;
    while (!v_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    ok = v_ready;
    @(posedge clk); #1;
    bus_a.Req_Valid = 1'b0;
    bus_b.Req_Valid = 1'b0;
  endtask

  task automatic do_req(input bit s, input bit wr, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata, input string tag,
                        output logic [31:0] got);
    int unsigned lat, exp_n, exp_rd, n, rd_cyc, wr_cyc;
    bit          err, seen, both, addr_bad, ok;
    logic [31:0] old_word, exp_data, new_word, got_wd, idx;
    idx      = addr / 4;
    lat      = s ? LatB : LatA;
    old_word = 32'h0;
    if (idx < Depth) old_word = s ? ref_b[idx[7:0]] : ref_a[idx[7:0]];
    model(old_word, wr, size, uns, addr, wdata, err, exp_data, new_word);
    exp_n  = err ? 0 : (!wr ? lat : (size == 2'd2 ? 1 : lat + 1));
    exp_rd = (err || (wr && size == 2'd2)) ? 0 : lat;
    sel    = s;
    set_req(s, 1'b1, wr, size, uns, addr, wdata);
    accept(ok);
    check({tag, ".accept"}, 32'(ok), 32'd1);
    n = 0; seen = 0; both = 0; addr_bad = 0; rd_cyc = 0; wr_cyc = 0; got_wd = 32'h0;
    while (n < 40) begin
      if (v_rv) begin
        seen = 1'b1;
        break;
      end
      if (v_mr && v_mw) both = 1'b1;
      if ((v_mr || v_mw) && v_addr != idx) addr_bad = 1'b1;
      if (v_mr) rd_cyc++;
      if (v_mw) begin
        wr_cyc++;
        got_wd = v_wd;
        if (v_addr < Depth) begin
          if (s) mem_b[v_addr[7:0]] = v_wd;
          else   mem_a[v_addr[7:0]] = v_wd;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    got = v_rdata;
    check({tag, ".latency"}, seen ? n : 32'hFFFF_FFFF, exp_n);
    check({tag, ".data"}, v_rdata, exp_data);
    check({tag, ".error"}, 32'(v_rerr), 32'(err));
    check({tag, ".reads"}, rd_cyc, exp_rd);
    check({tag, ".writes"}, wr_cyc, (wr && !err) ? 1 : 0);
    check({tag, ".strobe_excl_addr"}, 32'(both || addr_bad), 32'd0);
    if (wr && !err) begin
      check({tag, ".wdata"}, got_wd, new_word);
      if (s) ref_b[idx[7:0]] = new_word;
      else   ref_a[idx[7:0]] = new_word;
    end
    @(posedge clk); #1;
    check({tag, ".pulse_ready"}, {30'd0, v_rv, v_ready}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, w;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          ok, wr, s;
    int          rv_cnt, mw_cnt, bad_a, bad_b;
    set_req(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < int'(Depth); i++) begin
      w = $urandom; mem_a[i] = w; ref_a[i] = w;
      w = $urandom; mem_b[i] = w; ref_b[i] = w;
    end
    mem_a[7] = 32'h7;         ref_a[7] = 32'h7;
    mem_a[15] = 32'h1122_3344; ref_a[15] = 32'h1122_3344;
    mem_b[15] = 32'h1122_3344; ref_b[15] = 32'h1122_3344;

    #12;
    check("reset.a_ctl", {27'd0, bus_a.Req_Ready, bus_a.Resp_Valid, bus_a.Resp_Error, mw_a, mr_a},
          32'h10);
    check("reset.b_ctl", {27'd0, bus_b.Req_Ready, bus_b.Resp_Valid, bus_b.Resp_Error, mw_b, mr_b},
          32'h10);
    check("reset.a_addr", addr_a, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h1C, 32'h0, "ld_w7", got);
    check("ld_w7.val", got, 32'h7);
    do_req(1'b0, 1'b1, 2'd0, 1'b0, 32'h3D, 32'hAB, "st_b", got);
    check("st_b.mem15", mem_a[15], 32'h1122_AB44);
    do_req(1'b0, 1'b0, 2'd0, 1'b0, 32'h3D, 32'h0, "ld_bs", got);
    check("ld_bs.val", got, 32'hFFFF_FFAB);
    do_req(1'b0, 1'b0, 2'd0, 1'b1, 32'h3D, 32'h0, "ld_bu", got);
    check("ld_bu.val", got, 32'h0000_00AB);
    do_req(1'b0, 1'b0, 2'd1, 1'b0, 32'h3E, 32'h0, "ld_h", got);
    check("ld_h.val", got, 32'h0000_1122);
    do_req(1'b0, 1'b1, 2'd1, 1'b0, 32'h3F, 32'hBEEF, "st_h_err", got);
    check("st_h_err.mem15", mem_a[15], 32'h1122_AB44);
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "ld_oor", got);
    check("ld_oor.val", got, 32'h0);
    do_req(1'b0, 1'b1, 2'd2, 1'b0, 32'h08, 32'h55, "b2b_st", got);
    do_req(1'b0, 1'b0, 2'd2, 1'b0, 32'h08, 32'h0, "b2b_ld", got);
    check("b2b_ld.val", got, 32'h55);

    // Reset mid-cycle while a load is reading.
    sel = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h1C, 32'h0);
    accept(ok);
    check("rst_a.pre", {29'd0, ok, mr_a, mw_a}, 32'h6);
    check("rst_a.pre_addr", addr_a, 32'h7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_a.ctl", {27'd0, bus_a.Req_Ready, bus_a.Resp_Valid, bus_a.Resp_Error, mw_a, mr_a},
          32'h10);
    check("rst_a.addr", addr_a, 32'h0);
    check("rst_a.wdata", wd_a, 32'h0);
    check("rst_a.rdata", bus_a.Resp_Data, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency-3 sub-word store interrupted during its second read cycle.
    sel = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h3D, 32'hCD);
    accept(ok);
    check("rst_b.accept", 32'(ok), 32'd1);
    @(posedge clk); #2;
    check("rst_b.pre_mr", 32'(mr_b), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_b.async", {29'd0, bus_b.Req_Ready, mw_b, mr_b}, 32'h4);
    rv_cnt = 0; mw_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (i == 2) rst_n = 1'b1;
      rv_cnt += int'(bus_b.Resp_Valid);
      mw_cnt += int'(mw_b);
    end
    check("rst_b.no_resp", rv_cnt, 0);
    check("rst_b.no_write", mw_cnt, 0);
    do_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0, "rst_b.load", got);
    check("rst_b.mem15", got, 32'h1122_3344);

    for (int k = 0; k < 80; k++) begin
      s    = 1'($urandom_range(0, 1));
      wr   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      addr = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        if (size == 2'd2) addr[1:0] = 2'b00;
      end
      if ($urandom_range(0, 9) == 0) addr = addr + 32'h400 * $urandom_range(1, 8);
      do_req(s, wr, size, 1'($urandom_range(0, 1)), addr, $urandom, "rnd", got);
    end

    bad_a = 0; bad_b = 0;
    for (int i = 0; i < int'(Depth); i++) begin
      if (mem_a[i] !== ref_a[i]) bad_a++;
      if (mem_b[i] !== ref_b[i]) bad_b++;
    end
    check("final.mem_a", bad_a, 0);
    check("final.mem_b", bad_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
